// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU memory stage
// and a debug/loader port. The CPU normally has priority. A bounded wait counter
// forces a debug grant after MAX_WAIT consecutive losses. A lock mode hands the
// memory exclusively to the debugger for multi-cycle sequences.
// Grants are combinational, so read data returns in the same cycle as the grant.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_ONE   = CW'(1);

    typedef enum logic {
        CPU_PRI  = 1'b0,
        DBG_LOCK = 1'b1
    } st_t;

    st_t           st_q, st_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Arbitration decisions before reset gating; they also steer the next state.
    logic force_s;
    logic gnt_dbg_raw_s;
    logic gnt_cpu_raw_s;
    // Grants after reset gating; these drive the memory and the handshakes.
    logic gnt_dbg_s;
    logic gnt_cpu_s;

    // Pick the winner from the current mode, the requests and the starvation count.
    always_comb begin
        force_s       = 1'b0;
        gnt_dbg_raw_s = 1'b0;
        gnt_cpu_raw_s = 1'b0;
        case (st_q)
            CPU_PRI: begin
                force_s       = dbg_req & (wait_cnt_q == WAIT_LIMIT);
                gnt_dbg_raw_s = dbg_req & (~cpu_req | force_s);
                gnt_cpu_raw_s = cpu_req & ~gnt_dbg_raw_s;
            end
            DBG_LOCK: begin
                gnt_dbg_raw_s = dbg_req;
                gnt_cpu_raw_s = 1'b0;
            end
            default: begin
                gnt_dbg_raw_s = 1'b0;
                gnt_cpu_raw_s = 1'b0;
            end
        endcase
        // While reset is held, nothing is serviced and nothing is stalled.
        gnt_dbg_s = gnt_dbg_raw_s & reset;
        gnt_cpu_s = gnt_cpu_raw_s & reset;
    end

    // Route the granted side onto the memory bus and form the handshakes.
    always_comb begin
        cpu_stall = reset & cpu_req & ~gnt_cpu_raw_s;
        dbg_ack   = gnt_dbg_s;
        cpu_rdata = mem_rdata;
        dbg_rdata = mem_rdata;
        if (gnt_dbg_s) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (gnt_cpu_s) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            // Idle bus: address/data are don't-care, keep them on the CPU side.
            mem_we    = 1'b0;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Next mode and starvation count.
    always_comb begin
        st_d       = st_q;
        wait_cnt_d = wait_cnt_q;

        if (gnt_dbg_raw_s || !dbg_req) begin
            wait_cnt_d = '0;
        end else if (cpu_req && (wait_cnt_q != WAIT_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        case (st_q)
            CPU_PRI: begin
                if (gnt_dbg_raw_s && dbg_lock) begin
                    st_d = DBG_LOCK;
                end else begin
                    st_d = CPU_PRI;
                end
            end
            DBG_LOCK: begin
                // The cycle that drops the lock still honours dbg_req.
                if (!dbg_lock) begin
                    st_d = CPU_PRI;
                end else begin
                    st_d = DBG_LOCK;
                end
            end
            default: begin
                st_d = CPU_PRI;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q       <= CPU_PRI;
            wait_cnt_q <= '0;
        end else begin
            st_q       <= st_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized traffic. A driver
// applies one cycle of stimulus per negedge and pushes the expected response from
// a behavioural model; a separate monitor pops and compares it before the posedge.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
    logic          cpu_stall, dbg_ack, mem_we;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory behind the DUT (combinational read, write at posedge).
    logic [DW-1:0] phys_mem [32];
    assign mem_rdata = phys_mem[mem_addr[6:2]];
    always @(posedge clk) begin
        if (mem_we) phys_mem[mem_addr[6:2]] <= mem_wdata;
    end

    // Expected response for one cycle.
    typedef struct {
        int          cyc;
        bit          stall;
        bit          ack;
        bit          we;
        bit          chk_addr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_crd;
        bit          chk_drd;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    logic [31:0] model_mem [32];
    bit          locked;
    int          losses;
    int          cycle_no;

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle and push the model's expected response.
    task automatic cyc(input bit rst_n, input bit creq, input bit cwe, input logic [31:0] caddr,
                       input logic [31:0] cwdata, input bit dreq, input bit dwe, input bit dlock,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       output bit cpu_served, output bit dbg_served);
        exp_t e;
        bit   dbg_wins, cpu_wins;
        @(negedge clk);
        reset = rst_n; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwdata;
        dbg_req = dreq; dbg_we = dwe; dbg_lock = dlock; dbg_addr = daddr; dbg_wdata = dwdata;

        e = '{cyc: cycle_no, stall: 1'b0, ack: 1'b0, we: 1'b0, chk_addr: 1'b0, addr: 32'd0,
              wdata: 32'd0, chk_crd: 1'b0, chk_drd: 1'b0, rdata: 32'd0};
        cpu_served = 1'b0;
        dbg_served = 1'b0;
        if (!rst_n) begin
            locked = 1'b0;
            losses = 0;
        end else begin
            // Debug wins when it owns the memory, when the CPU is idle,
            // or when it has already lost MAX_WAIT cycles in a row.
            dbg_wins = dreq && (locked || !creq || losses >= MAX_WAIT);
            cpu_wins = creq && !locked && !dbg_wins;
            e.stall  = creq && !cpu_wins;
            e.ack    = dbg_wins;
            if (dbg_wins) begin
                e.we = dwe; e.chk_addr = 1'b1; e.addr = daddr; e.wdata = dwdata;
                e.chk_drd = 1'b1; e.rdata = model_mem[daddr[6:2]];
                if (dwe) model_mem[daddr[6:2]] = dwdata;
            end else if (cpu_wins) begin
                e.we = cwe; e.chk_addr = 1'b1; e.addr = caddr; e.wdata = cwdata;
                e.chk_crd = 1'b1; e.rdata = model_mem[caddr[6:2]];
                if (cwe) model_mem[caddr[6:2]] = cwdata;
            end
            if (dbg_wins || !dreq) losses = 0;
            else if (losses < MAX_WAIT) losses++;
            if (locked && !dlock) locked = 1'b0;
            else if (!locked && dbg_wins && dlock) locked = 1'b1;
            cpu_served = cpu_wins;
            dbg_served = dbg_wins;
        end
        exp_q.push_back(e);
        cycle_no++;
    endtask

    // Monitor: compare DUT outputs well before the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cpu_stall", e.cyc, {31'd0, cpu_stall}, {31'd0, e.stall});
                chk("dbg_ack",   e.cyc, {31'd0, dbg_ack},   {31'd0, e.ack});
                chk("mem_we",    e.cyc, {31'd0, mem_we},    {31'd0, e.we});
                if (e.chk_addr) chk("mem_addr", e.cyc, mem_addr, e.addr);
                if (e.chk_addr && e.we) chk("mem_wdata", e.cyc, mem_wdata, e.wdata);
                if (e.chk_crd) chk("cpu_rdata", e.cyc, cpu_rdata, e.rdata);
                if (e.chk_drd) chk("dbg_rdata", e.cyc, dbg_rdata, e.rdata);
            end
        end
    end

    initial begin
        bit          cs, ds;
        bit          c_pend, c_we, d_pend, d_we, want_lock;
        logic [31:0] c_addr, c_wd, d_addr, d_wd;
        n_tests = 0; n_fail = 0; cycle_no = 0; locked = 1'b0; losses = 0;
        for (int i = 0; i < 32; i++) begin
            phys_mem[i]  = 32'd0;
            model_mem[i] = 32'd0;
        end
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;

        // Reset held with a pending CPU store: nothing may reach memory.
        repeat (2) cyc(1'b0, 1'b1, 1'b1, 32'd100, 32'd25, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, cs, ds);
        // CPU store alone.
        cyc(1'b1, 1'b1, 1'b1, 32'd100, 32'd25, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, cs, ds);
        cyc(1'b1, 1'b1, 1'b1, 32'd96, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, cs, ds);
        // Debug read with the CPU idle: same-cycle data.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd96, 32'd0, cs, ds);
        // Starvation bound: four losses, forced grant on the fifth cycle, CPU next.
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 32'd96, 32'd0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd0, cs, ds);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'd100, 32'd0, 1'b1, 1'b1, 1'b0, 32'd8, 32'd55, cs, ds);
        // Same-address write collision under CPU priority.
        cyc(1'b1, 1'b1, 1'b1, 32'd12, 32'd11, 1'b1, 1'b1, 1'b0, 32'd12, 32'd22, cs, ds);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd12, 32'd0, cs, ds);
        // Lock sequence: grant with lock, hold several cycles, drop lock.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd100, 32'd0, cs, ds);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 1'b1, 32'd4, 32'd9, i[0], 1'b1, 1'b1, 32'd16, 32'(i + 40), cs, ds);
        cyc(1'b1, 1'b1, 1'b1, 32'd4, 32'd9, 1'b1, 1'b0, 1'b0, 32'd16, 32'd0, cs, ds);
        cyc(1'b1, 1'b1, 1'b1, 32'd4, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, cs, ds);
        // Reset in the middle of a lock, then CPU is granted straight away.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd4, 32'd0, cs, ds);
        cyc(1'b1, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1, 32'd4, 32'd0, cs, ds);
        cyc(1'b0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1, 32'd4, 32'd0, cs, ds);
        cyc(1'b1, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1, 32'd8, 32'd0, cs, ds);
        cyc(1'b1, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, cs, ds);

        // Randomized traffic: each side holds its request until serviced.
        c_pend = 1'b0; d_pend = 1'b0; want_lock = 1'b0;
        c_we = 1'b0; d_we = 1'b0; c_addr = 32'd0; d_addr = 32'd0; c_wd = 32'd0; d_wd = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            if (!c_pend && $urandom_range(0, 3) != 0) begin
                c_pend = 1'b1; c_we = 1'($urandom_range(0, 1));
                c_addr = {25'd0, 5'($urandom_range(0, 7)), 2'b00}; c_wd = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = {25'd0, 5'($urandom_range(0, 7)), 2'b00}; d_wd = $urandom;
            end
            if ($urandom_range(0, 9) == 0) want_lock = ~want_lock;
            cyc(($urandom_range(0, 199) != 0), c_pend, c_we, c_addr, c_wd,
                d_pend, d_we, want_lock, d_addr, d_wd, cs, ds);
            if (cs) c_pend = 1'b0;
            if (ds) d_pend = 1'b0;
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #4;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
